// File: rtl/axi_alu_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_alu_rx                                                      |
// | Brief    : Pops two-word operand frames from a valid/ready FIFO read port,  |
// |            runs an 8-bit ALU op and presents a registered result word.      |
// |            Optional ALU_FRAME_CHECK_EN flags a non-zero word-1 opcode field.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module axi_alu_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] rdata,
  input  logic       rvalid,
  output logic       rready,
  output logic [9:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] op_count,
  output logic       err
);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic [7:0] r_a;
  logic [9:0] r_res;
  logic [7:0] r_count;
  logic       r_err;
  logic       w_bad;
  logic [8:0] w_sum;
  logic [7:0] w_r;
  logic       w_cf;

`ifdef ALU_FRAME_CHECK_EN
  assign w_bad = (rdata[9:8] != 2'b00);
`else
  assign w_bad = 1'b0;
`endif

  // Word 1 operand comes straight from rdata; result is registered on pop.
  always_comb begin
    w_sum = 9'd0;
    w_r   = 8'd0;
    w_cf  = 1'b0;
    case (r_op)
      2'b00: begin
        w_sum = {1'b0, r_a} + {1'b0, rdata[7:0]};
        w_r   = w_sum[7:0];
        w_cf  = w_sum[8];
      end
      2'b01: begin
        w_sum = {1'b0, r_a} - {1'b0, rdata[7:0]};
        w_r   = w_sum[7:0];
        w_cf  = w_sum[8];
      end
      2'b10:   w_r = r_a & rdata[7:0];
      default: w_r = r_a ^ rdata[7:0];
    endcase
  end

  always_comb begin
    w_next    = r_state;
    rready    = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      S_A: begin
        rready = 1'b1;
        if (rvalid) w_next = S_B;
      end
      S_B: begin
        rready = 1'b1;
        if (rvalid) w_next = w_bad ? S_A : S_OUT;
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_A;
      end
      default: w_next = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_A;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op    <= 2'b00;
      r_a     <= 8'h00;
      r_res   <= 10'h000;
      r_count <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == S_A && rvalid) begin
        r_op <= rdata[9:8];
        r_a  <= rdata[7:0];
      end
      if (r_state == S_B && rvalid) begin
        if (w_bad) r_err <= 1'b1;
        else       r_res <= {(w_r == 8'h00), w_cf, w_r};
      end
      if (r_state == S_OUT && res_ready) r_count <= r_count + 8'd1;
    end
  end

  assign res_data = r_res;
  assign op_count = r_count;
  assign err      = r_err;

endmodule
`default_nettype wire
